// File: rtl/frame_pkg.sv
// Shared types and constants for the UART frame decoder.
// The command codes are also used by the command control FSM.
package frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    CMD,
    LEN,
    PAYLOAD,
    CHK
  } state_e;

  localparam logic [7:0] HDR0 = 8'hAA;
  localparam logic [7:0] HDR1 = 8'h55;

  localparam logic [7:0] CMD_SPI    = 8'h01;
  localparam logic [7:0] CMD_I2C    = 8'h02;
  localparam logic [7:0] CMD_DUT_EN = 8'h03;

endpackage

// File: rtl/frame_parser_if.sv
// Byte-stream input and decoded-frame output bundle of frame_parser.
// The slave modport is the parser side; master is the UART/consumer side.
interface frame_parser_if #(
  parameter int MAX_LEN = 16
) ();

  logic [7:0]               rx_data;
  logic                     rx_valid;
  logic                     frame_valid;
  logic [7:0]               cmd_type;
  logic [7:0]               payload_len;
  logic [$clog2(MAX_LEN)-1:0] pl_rd_addr;
  logic [7:0]               pl_rd_data;
  logic                     crc_err;
  logic                     len_err;
  logic                     timeout_err;

  modport slave (
    input  rx_data,
    input  rx_valid,
    input  pl_rd_addr,
    output frame_valid,
    output cmd_type,
    output payload_len,
    output pl_rd_data,
    output crc_err,
    output len_err,
    output timeout_err
  );

  modport master (
    output rx_data,
    output rx_valid,
    output pl_rd_addr,
    input  frame_valid,
    input  cmd_type,
    input  payload_len,
    input  pl_rd_data,
    input  crc_err,
    input  len_err,
    input  timeout_err
  );

endinterface

// File: rtl/frame_payload_ram.sv
// Single-bank payload buffer: synchronous write, asynchronous read.
// Contents are not reset; only bytes of the last good frame are meaningful.
module frame_payload_ram #(
  parameter int MAX_LEN = 16,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/frame_parser.sv
// Header-hunting frame decoder: HDR0 HDR1 CMD LEN payload CHK, where CHK is
// the XOR of CMD, LEN and payload. Good frames pulse frame_valid, bad ones an error.
module frame_parser #(
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] HDR0        = frame_pkg::HDR0,
  parameter logic [7:0] HDR1        = frame_pkg::HDR1
) (
  input logic           clk,
  input logic           rst_n,
  frame_parser_if.slave bus
);

  import frame_pkg::*;

  localparam int              AW        = $clog2(MAX_LEN);
  localparam int              TW        = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [8:0]      MAX_LEN_W = 9'(MAX_LEN);

  state_e        state_q, state_d;
  logic [7:0]    cmd_w_q, cmd_w_d;
  logic [7:0]    len_w_q, len_w_d;
  logic [7:0]    idx_q, idx_d;
  logic [7:0]    xor_q, xor_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]    cmd_type_q, cmd_type_d;
  logic [7:0]    payload_len_q, payload_len_d;
  logic          frame_valid_q, frame_valid_d;
  logic          crc_err_q, crc_err_d;
  logic          len_err_q, len_err_d;
  logic          timeout_err_q, timeout_err_d;
  logic          ram_we;

  always_comb begin
    state_d       = state_q;
    cmd_w_d       = cmd_w_q;
    len_w_d       = len_w_q;
    idx_d         = idx_q;
    xor_d         = xor_q;
    cmd_type_d    = cmd_type_q;
    payload_len_d = payload_len_q;
    frame_valid_d = 1'b0;
    crc_err_d     = 1'b0;
    len_err_d     = 1'b0;
    timeout_err_d = 1'b0;
    ram_we        = 1'b0;
    tmo_cnt_d     = (bus.rx_valid || state_q == IDLE) ? '0 : tmo_cnt_q + TW'(1);

    if (bus.rx_valid) begin
      unique case (state_q)
        IDLE: begin
          if (bus.rx_data == HDR0) state_d = HDR;
        end
        HDR: begin
          // A repeated HDR0 may be the true start of a frame, so keep hunting.
          if (bus.rx_data == HDR1)      state_d = CMD;
          else if (bus.rx_data != HDR0) state_d = IDLE;
        end
        CMD: begin
          cmd_w_d = bus.rx_data;
          xor_d   = bus.rx_data;
          state_d = LEN;
        end
        LEN: begin
          xor_d = xor_q ^ bus.rx_data;
          if ({1'b0, bus.rx_data} > MAX_LEN_W) begin
            len_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            len_w_d = bus.rx_data;
            idx_d   = '0;
            state_d = (bus.rx_data == 8'd0) ? CHK : PAYLOAD;
          end
        end
        PAYLOAD: begin
          ram_we = 1'b1;
          xor_d  = xor_q ^ bus.rx_data;
          idx_d  = idx_q + 8'd1;
          if (idx_q + 8'd1 == len_w_q) state_d = CHK;
        end
        CHK: begin
          if (bus.rx_data == xor_q) begin
            frame_valid_d = 1'b1;
            cmd_type_d    = cmd_w_q;
            payload_len_d = len_w_q;
          end else begin
            crc_err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && tmo_cnt_q == TMO_LAST) begin
      // A byte arriving on the expiry cycle takes the branch above instead.
      timeout_err_d = 1'b1;
      state_d       = IDLE;
      tmo_cnt_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_w_q       <= '0;
      len_w_q       <= '0;
      idx_q         <= '0;
      xor_q         <= '0;
      tmo_cnt_q     <= '0;
      cmd_type_q    <= '0;
      payload_len_q <= '0;
      frame_valid_q <= 1'b0;
      crc_err_q     <= 1'b0;
      len_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cmd_w_q       <= cmd_w_d;
      len_w_q       <= len_w_d;
      idx_q         <= idx_d;
      xor_q         <= xor_d;
      tmo_cnt_q     <= tmo_cnt_d;
      cmd_type_q    <= cmd_type_d;
      payload_len_q <= payload_len_d;
      frame_valid_q <= frame_valid_d;
      crc_err_q     <= crc_err_d;
      len_err_q     <= len_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  frame_payload_ram #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_payload_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (idx_q[AW-1:0]),
    .wr_data (bus.rx_data),
    .rd_addr (bus.pl_rd_addr),
    .rd_data (bus.pl_rd_data)
  );

  assign bus.frame_valid = frame_valid_q;
  assign bus.cmd_type    = cmd_type_q;
  assign bus.payload_len = payload_len_q;
  assign bus.crc_err     = crc_err_q;
  assign bus.len_err     = len_err_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
